// File: rtl/apb_timer.sv
// apb_timer: 16-bit programmable interval timer on the 8-bit io APB bus.
// 8-bit prescaler, 16-bit up-counter with equality compare against LIMIT,
// optional auto-reload and a registered level interrupt. APB accesses take
// one wait state (pready is registered).
// Optional capture input is enabled by defining APB_TIMER_CAPTURE_EN.
module apb_timer #(
  parameter logic [7:0]  PRESCALE_RESET = 8'h00,
  parameter logic [15:0] LIMIT_RESET    = 16'hFFFF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] bus_if_paddr,
  input  logic       bus_if_psel,
  input  logic       bus_if_penable,
  input  logic       bus_if_pwrite,
  input  logic [7:0] bus_if_pwdata,
  output logic [7:0] bus_if_prdata,
  output logic       bus_if_pready,
  input  logic       capture,
  output logic       interrupt
);

  logic        en;
  logic        auto_reload;
  logic        irq_en;
  logic        pend;
  logic        capt;
  logic [15:0] limit;
  logic [7:0]  limit_hold;
  logic [7:0]  prescale;
  logic [7:0]  pcnt;
  logic [15:0] count;
  logic [7:0]  count_snap;
  logic [15:0] capture_val;
  logic [7:0]  rdata;

  logic access;
  logic rd_phase;
  logic wr_commit;
  logic wr_ctrl;
  logic wr_status;
  logic tick;
  logic expire;

  // Transfer phase decode and counter events
  always_comb begin
    access    = bus_if_psel & bus_if_penable;
    rd_phase  = access & ~bus_if_pready;
    wr_commit = access & bus_if_pready & bus_if_pwrite;
    wr_ctrl   = wr_commit & (bus_if_paddr == 4'd0);
    wr_status = wr_commit & (bus_if_paddr == 4'd1);
    tick      = en & (pcnt == 8'd0);
    expire    = tick & (count == limit);
  end

  // Read data multiplexer
  always_comb begin
    rdata = 8'h00;
    case (bus_if_paddr)
      4'd0: rdata = {5'b0, irq_en, auto_reload, en};
      4'd1: rdata = {6'b0, capt, pend};
      4'd2: rdata = limit[7:0];
      4'd3: rdata = limit[15:8];
      4'd4: rdata = count[7:0];
      4'd5: rdata = count_snap;
      4'd6: rdata = prescale;
      4'd8: rdata = capture_val[7:0];
      4'd9: rdata = capture_val[15:8];
      default: rdata = 8'h00;
    endcase
  end

  // APB handshake: read data and the COUNT_HI snapshot are taken together so
  // a LO-then-HI read pair is coherent across a carry
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bus_if_pready <= 1'b0;
      bus_if_prdata <= 8'h00;
      count_snap    <= 8'h00;
    end else begin
      bus_if_pready <= rd_phase;
      if (rd_phase) bus_if_prdata <= rdata;
      if (rd_phase && !bus_if_pwrite && bus_if_paddr == 4'd4)
        count_snap <= count[15:8];
    end
  end

  // Configuration registers; LIMIT is committed atomically on the HI write
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      limit      <= LIMIT_RESET;
      limit_hold <= 8'h00;
      prescale   <= PRESCALE_RESET;
    end else if (wr_commit) begin
      case (bus_if_paddr)
        4'd2: limit_hold <= bus_if_pwdata;
        4'd3: limit      <= {bus_if_pwdata, limit_hold};
        4'd6: prescale   <= bus_if_pwdata;
        default: ;
      endcase
    end
  end

  // Prescaler, counter, control bits and pending flag; later assignments
  // give the CTRL write priority over an expiry, and PEND set over W1C
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      pend        <= 1'b0;
      pcnt        <= 8'h00;
      count       <= 16'h0000;
    end else begin
      if (en) begin
        if (pcnt == 8'd0) begin
          pcnt  <= prescale;
          count <= (count == limit) ? 16'h0000 : count + 16'd1;
        end else begin
          pcnt <= pcnt - 8'd1;
        end
      end
      if (expire && !auto_reload) en <= 1'b0;
      if (wr_ctrl) begin
        en          <= bus_if_pwdata[0];
        auto_reload <= bus_if_pwdata[1];
        irq_en      <= bus_if_pwdata[2];
        if (bus_if_pwdata[0] && !en) begin
          count <= 16'h0000;
          pcnt  <= prescale;
        end
      end
      if (expire) pend <= 1'b1;
      else if (wr_status && bus_if_pwdata[0]) pend <= 1'b0;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (!n_rst) interrupt <= 1'b0;
    else        interrupt <= pend & irq_en;
  end

`ifdef APB_TIMER_CAPTURE_EN
  logic sync1;
  logic sync2;
  logic sync3;

  // Two-flop synchronizer, rising-edge detect and count capture
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      capt        <= 1'b0;
      capture_val <= 16'h0000;
    end else begin
      sync1 <= capture;
      sync2 <= sync1;
      sync3 <= sync2;
      if (sync2 && !sync3) begin
        capture_val <= count;
        capt        <= 1'b1;
      end else if (wr_status && bus_if_pwdata[1]) begin
        capt <= 1'b0;
      end
    end
  end
`else
  logic capture_unused;
  assign capture_unused = capture;
  assign capt           = 1'b0;
  assign capture_val    = 16'h0000;
`endif

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: table-driven register checks, hand sequences for timing
// corner cases, and randomized interval runs against an arithmetic model.
module tb_apb_timer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] paddr = 4'd0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       capture = 1'b0;
  logic       interrupt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  apb_timer dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus_if_paddr(paddr),
    .bus_if_psel(psel),
    .bus_if_penable(penable),
    .bus_if_pwrite(pwrite),
    .bus_if_pwdata(pwdata),
    .bus_if_prdata(prdata),
    .bus_if_pready(pready),
    .capture(capture),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                      output logic [7:0] rd);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pready_acc1", pready, 0);
    @(posedge clk); #1;
    chk("pready_acc2", pready, 1);
    rd = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("pready_done", pready, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] r);
    xfer(1'b0, a, 8'h00, r);
  endtask

  // Wait for interrupt to be high after an edge; returns edge number or -1
  task automatic wait_irq(output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (interrupt) begin
        t = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c, c2, t, n, ecount, pp, ll, au, dd;
    logic epend;
    logic [7:0] r, lo, hi;

    tbl[0]  = '{1'b0, 4'd0,  8'h00, 8'h00};
    tbl[1]  = '{1'b0, 4'd1,  8'h00, 8'h00};
    tbl[2]  = '{1'b0, 4'd2,  8'h00, 8'hFF};
    tbl[3]  = '{1'b0, 4'd3,  8'h00, 8'hFF};
    tbl[4]  = '{1'b0, 4'd4,  8'h00, 8'h00};
    tbl[5]  = '{1'b0, 4'd5,  8'h00, 8'h00};
    tbl[6]  = '{1'b0, 4'd6,  8'h00, 8'h00};
    tbl[7]  = '{1'b0, 4'd7,  8'h00, 8'h00};
    tbl[8]  = '{1'b0, 4'd8,  8'h00, 8'h00};
    tbl[9]  = '{1'b0, 4'd9,  8'h00, 8'h00};
    tbl[10] = '{1'b0, 4'd15, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 4'd7,  8'hAA, 8'h00};
    tbl[12] = '{1'b0, 4'd7,  8'h00, 8'h00};
    tbl[13] = '{1'b1, 4'd4,  8'h55, 8'h00};
    tbl[14] = '{1'b0, 4'd4,  8'h00, 8'h00};
    tbl[15] = '{1'b1, 4'd6,  8'h5A, 8'h00};
    tbl[16] = '{1'b0, 4'd6,  8'h00, 8'h5A};
    tbl[17] = '{1'b1, 4'd0,  8'hFE, 8'h00};
    tbl[18] = '{1'b0, 4'd0,  8'h00, 8'h06};
    tbl[19] = '{1'b1, 4'd0,  8'h00, 8'h00};
    tbl[20] = '{1'b0, 4'd0,  8'h00, 8'h00};
    tbl[21] = '{1'b1, 4'd2,  8'h10, 8'h00};
    tbl[22] = '{1'b0, 4'd2,  8'h00, 8'hFF};
    tbl[23] = '{1'b0, 4'd3,  8'h00, 8'hFF};
    tbl[24] = '{1'b1, 4'd3,  8'h00, 8'h00};
    tbl[25] = '{1'b0, 4'd2,  8'h00, 8'h10};
    tbl[26] = '{1'b0, 4'd3,  8'h00, 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 0);
    chk("rst_pready", pready, 0);
    chk("rst_irq", interrupt, 0);
    n_rst = 1'b1;

    // Register table
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].w) begin
        wr(tbl[i].a, tbl[i].d);
      end else begin
        rd(tbl[i].a, r);
        chk($sformatf("vec%0d_addr%0d", i, tbl[i].a), r, tbl[i].exp);
      end
    end

    // Aborted write: psel dropped before the commit cycle
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd6; pwdata = 8'h11;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", pready, 0);
    rd(4'd6, r);
    chk("abort_prescale", r, 8'h5A);

    // Auto-reload interval: PRESCALE=3, LIMIT=4 -> 20 clocks per expiry
    wr(4'd6, 8'h03); wr(4'd2, 8'h04); wr(4'd3, 8'h00); wr(4'd1, 8'h01);
    wr(4'd0, 8'h07);
    c = cyc;
    wait_irq(t);
    chk("irq_first", t, c + 21);
    wr(4'd1, 8'h01);
    wait_irq(t);
    chk("irq_second", t, c + 41);

    // One-shot: single expiry clears EN, count holds at 0
    wr(4'd0, 8'h00); wr(4'd1, 8'h01);
    wr(4'd0, 8'h05);
    c = cyc;
    wait_irq(t);
    chk("oneshot_irq", t, c + 21);
    repeat (30) @(posedge clk);
    rd(4'd0, r); chk("oneshot_ctrl", r, 8'h04);
    rd(4'd4, r); chk("oneshot_cnt_lo", r, 8'h00);
    rd(4'd5, r); chk("oneshot_cnt_hi", r, 8'h00);
    wr(4'd1, 8'h01);
    chk("w1c_irq_same", interrupt, 1);
    @(posedge clk); #1;
    chk("w1c_irq_next", interrupt, 0);

    // Coherent COUNT read across the 0x00FF -> 0x0100 carry
    wr(4'd6, 8'h00); wr(4'd2, 8'hFF); wr(4'd3, 8'hFF);
    wr(4'd0, 8'h01);
    repeat (253) @(posedge clk);
    rd(4'd4, lo);
    rd(4'd5, hi);
    chk("carry_lo", lo, 8'hFF);
    chk("carry_hi", hi, 8'h00);

    // STATUS W1C in the same cycle as an expiry: PEND stays set
    wr(4'd0, 8'h00); wr(4'd2, 8'h09); wr(4'd3, 8'h00); wr(4'd1, 8'h01);
    wr(4'd0, 8'h03);
    repeat (16) @(posedge clk);
    wr(4'd1, 8'h01);
    rd(4'd1, r);
    chk("w1c_vs_set", r[0], 1);

    // Randomized intervals against the arithmetic model
    for (int it = 0; it < 8; it++) begin
      pp = $urandom_range(0, 3);
      ll = $urandom_range(0, 7);
      au = $urandom_range(0, 1);
      dd = $urandom_range(0, 60);
      wr(4'd0, 8'h00); wr(4'd1, 8'h01);
      wr(4'd6, 8'(pp)); wr(4'd2, 8'(ll)); wr(4'd3, 8'h00);
      wr(4'd0, 8'(5 + 2 * au));
      c = cyc;
      repeat (dd) @(posedge clk);
      wr(4'd0, 8'h04);
      c2 = cyc;
      n = (c2 - c) / (pp + 1);
      if (au != 0) begin
        ecount = n % (ll + 1);
        epend  = (n >= ll + 1);
      end else if (n >= ll + 1) begin
        ecount = 0;
        epend  = 1'b1;
      end else begin
        ecount = n;
        epend  = 1'b0;
      end
      rd(4'd4, lo);
      rd(4'd5, hi);
      chk($sformatf("rand%0d_count", it), {16'h0, hi, lo}, ecount);
      rd(4'd1, r);
      chk($sformatf("rand%0d_pend", it), r[0], epend);
      chk($sformatf("rand%0d_irq", it), interrupt, epend);
    end

`ifdef APB_TIMER_CAPTURE_EN
    // Capture of a frozen count
    wr(4'd0, 8'h00);
    rd(4'd4, lo);
    rd(4'd5, hi);
    capture = 1'b1;
    repeat (6) @(posedge clk);
    capture = 1'b0;
    rd(4'd8, r); chk("capt_lo", r, lo);
    rd(4'd9, r); chk("capt_hi", r, hi);
    rd(4'd1, r); chk("capt_flag", r[1], 1);
`else
    capture = 1'b1;
    repeat (6) @(posedge clk);
    capture = 1'b0;
    rd(4'd8, r); chk("nocapt_lo", r, 8'h00);
    rd(4'd9, r); chk("nocapt_hi", r, 8'h00);
    rd(4'd1, r); chk("nocapt_flag", r[1], 0);
`endif

    // Reset asserted mid-transfer drops it and restores reset values
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd6; pwdata = 8'h33;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pready", pready, 0);
    chk("midrst_prdata", prdata, 0);
    chk("midrst_irq", interrupt, 0);
    n_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd(4'd6, r); chk("midrst_prescale", r, 8'h00);
    rd(4'd3, r); chk("midrst_limit_hi", r, 8'hFF);
    rd(4'd0, r); chk("midrst_ctrl", r, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- 16-bit programmable interval timer on the FPGA system's 8-bit io APB bus, alongside the UART.
- Consumes APB transactions produced by the system block's io bus. The top level decodes psel from paddr[15:8].
- Provides an 8-bit prescaler, 16-bit up-counter with compare/limit, auto-reload and a level interrupt.
- Runs in the same clock domain as the io APB bus.

Parameters:
- PRESCALE_RESET, 8'h00, reset value of PRESCALE register.
- LIMIT_RESET, 16'hFFFF, reset value of LIMIT register.

Ports:
- clk  input  1  APB/timer clock.
- n_rst  input  1  synchronous active-low reset, sampled on rising clk.
- bus_if_paddr  input  4  register select.
- bus_if_psel  input  1  APB select (pre-decoded).
- bus_if_penable  input  1  APB access phase.
- bus_if_pwrite  input  1  1=write.
- bus_if_pwdata  input  8  write data.
- bus_if_prdata  output  8  read data.
- bus_if_pready  output  1  transfer complete.
- capture  input  1  async capture strobe; only used with the optional feature.
- interrupt  output  1  level interrupt.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - prdata=0, pready=0, interrupt=0.
  - CTRL=0, STATUS=0, count=0, prescale counter=0.
  - LIMIT=LIMIT_RESET, PRESCALE=PRESCALE_RESET, limit_lo holding=0.
- APB timing: one wait state.
  - Setup: psel & !penable.
  - Access cycle 1: pready=0.
  - Access cycle 2: pready=1, prdata valid.
  - Write side effects commit on the pready=1 cycle.
  - pready is registered and drops the cycle after completion.
  - psel deasserted mid-transfer aborts with no side effects.
- Register map (paddr[3:0]):
  - 0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 1 STATUS: [0] PEND, write-1-to-clear.
  - 2 LIMIT_LO: writes a holding register; reads the committed LIMIT[7:0].
  - 3 LIMIT_HI: a write commits {pwdata, holding} to LIMIT atomically.
  - 4 COUNT_LO: a read returns count[7:0] and snapshots count[15:8].
  - 5 COUNT_HI: returns the snapshot.
  - 6 PRESCALE: read/write.
  - 7 reserved, reads 0.
  - 8/9 CAPTURE_LO/HI (optional feature).
  - Writes to read-only or reserved addresses are ignored; no error response.
- Counting:
  - When EN=1, the prescale counter decrements each clk.
  - When it is 0, a tick is generated and it reloads PRESCALE. Tick period = PRESCALE+1 clocks.
  - On a tick, if count==LIMIT: count<=0, PEND<=1, and if AUTO_RELOAD=0 then EN<=0. Otherwise count<=count+1.
  - Compare is equality only. If LIMIT is lowered below count, count runs to 16'hFFFF, wraps to 0 without PEND, then matches.
  - LIMIT=0 expires on every tick.
- CTRL write with EN 0->1 clears count and loads the prescale counter with PRESCALE. First tick occurs PRESCALE+1 clocks later.
- EN=0 freezes count and the prescale counter.
- Simultaneous events:
  - A hardware PEND set in the same cycle as a STATUS W1C: set wins.
  - A CTRL write in the same cycle as an expiry clearing EN: the CTRL write wins.
- interrupt is registered: interrupt <= PEND & IRQ_EN, one clock after PEND/IRQ_EN change.
- n_rst low mid-transfer returns all state to reset values. The pending transfer is dropped, with pready=0.

Optional Feature:
- Macro: APB_TIMER_CAPTURE_EN.
- Defined:
  - capture passes through a 2-flop synchronizer plus a rising-edge detect.
  - On the detected edge, count is latched into CAPTURE (16 bits) and STATUS[1] CAPT is set (W1C, set wins).
  - Edge-to-latch latency is 3 clocks.
  - Registers 8/9 return CAPTURE[7:0]/[15:8].
- Undefined:
  - capture is ignored; addresses 8/9 read 0; STATUS[1] reads 0.
  - No synchronizer flops are instantiated.

Test Plan:
- Reset then read all addresses -> CTRL=0x00, STATUS=0x00, LIMIT_LO/HI=0xFF/0xFF, PRESCALE=0x00, others 0x00. Each access has pready high exactly one cycle, 2 cycles after setup.
- PRESCALE=3, LIMIT_LO=0x04, LIMIT_HI=0x00, CTRL=0x07 -> PEND sets 20 clocks after the CTRL commit. interrupt rises 1 clock later and repeats every 20 clocks.
- Same setup with CTRL=0x05 (one-shot) -> single PEND, then CTRL reads 0x04 and count holds at 0. A STATUS write of 0x01 clears interrupt next clock.
- LIMIT_LO=0x10 write only (no HI write) -> LIMIT reads 0xFFFF and does not change until LIMIT_HI=0x00 is written, after which it reads 0x0010.
- Count at 0x00FF read via COUNT_LO then COUNT_HI across the carry -> returns 0xFF then 0x00 (the snapshot is coherent). Forcing a STATUS W1C in the same cycle as an expiry -> PEND stays 1.
- (APB_TIMER_CAPTURE_EN) Pulse capture with count=0x1234 -> CAPTURE reads 0x34/0x12 and STATUS=0x02|PEND. Without the macro, addresses 8/9 read 0x00.
